// File: rtl/post_mux_pkg.sv
// Shared constants and FSM state type for the post-mux response collector.
// Build macro POST_MUX_PARITY_EN appends an XOR parity byte to every stream.
package post_mux_pkg;

    localparam int N_BITS    = 128;
    localparam int IDX_W     = 7;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = N_BITS / BYTE_W;
`ifdef POST_MUX_PARITY_EN
    localparam int TX_BYTES  = NUM_BYTES + 1;
`else
    localparam int TX_BYTES  = NUM_BYTES;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } state_t;

endpackage

// File: rtl/post_mux_byte_sel.sv
// Combinational byte slice of the response buffer selected by byte index.
// With POST_MUX_PARITY_EN, indices past the data bytes return the XOR of all data bytes.
module post_mux_byte_sel #(
    parameter int N_BITS = 128,
    parameter int BYTE_W = 8,
    parameter int BIDX_W = 4
) (
    input  logic [N_BITS-1:0] buf_bits,
    input  logic [BIDX_W-1:0] byte_idx,
    output logic [BYTE_W-1:0] byte_out
);

    localparam int NUM_BYTES = N_BITS / BYTE_W;
    localparam int BSEL_W    = $clog2(NUM_BYTES);
    localparam int BW_LOG    = $clog2(BYTE_W);

    logic [BSEL_W+BW_LOG-1:0] base_s;
    logic [BYTE_W-1:0]        data_byte_s;

    assign base_s      = {byte_idx[BSEL_W-1:0], {BW_LOG{1'b0}}};
    assign data_byte_s = buf_bits[base_s +: BYTE_W];

`ifdef POST_MUX_PARITY_EN
    function automatic logic [BYTE_W-1:0] xor_bytes(input logic [N_BITS-1:0] bits);
        logic [BYTE_W-1:0] acc;
        acc = {BYTE_W{1'b0}};
        for (int i = 0; i < NUM_BYTES; i++) begin
            acc = acc ^ bits[i*BYTE_W +: BYTE_W];
        end
        return acc;
    endfunction

    // Select between a data byte and the trailing parity byte.
    always_comb begin
        if (int'(byte_idx) >= NUM_BYTES) begin
            byte_out = xor_bytes(buf_bits);
        end else begin
            byte_out = data_byte_s;
        end
    end
`else
    assign byte_out = data_byte_s;
`endif

endmodule

// File: rtl/post_mux_collector.sv
// Collects one PUF response bit per mux index into a buffer, then streams it as bytes.
// Build macro POST_MUX_PARITY_EN adds a trailing XOR parity byte after the data bytes.
module post_mux_collector #(
    parameter int N_BITS = post_mux_pkg::N_BITS,
    parameter int IDX_W  = post_mux_pkg::IDX_W,
    parameter int BYTE_W = post_mux_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic [IDX_W-1:0]  idx,
    input  logic              last,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import post_mux_pkg::*;

    localparam int NUM_B = N_BITS / BYTE_W;
`ifdef POST_MUX_PARITY_EN
    localparam int TXB   = NUM_B + 1;
`else
    localparam int TXB   = NUM_B;
`endif
    localparam int BIDX_W = $clog2(TXB);
    localparam int CNT_W  = IDX_W + 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(N_BITS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]    CNT_FULL  = (CNT_W+1)'(N_BITS);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(TXB - 1);
    localparam logic [BIDX_W-1:0] BIDX_ONE  = {{(BIDX_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [N_BITS-1:0]  buf_r, buf_s;
    logic [CNT_W-1:0]   rx_cnt_r, rx_cnt_s;
    logic [BIDX_W-1:0]  byte_idx_r, byte_idx_s;
    logic [BYTE_W-1:0]  tx_data_r, tx_data_s, sel_byte_s;
    logic               tx_valid_r, tx_valid_s;
    logic               busy_r, done_r, done_s, err_r, err_s;

    // Byte selection looks at the next buffer/index so byte 0 is ready the cycle SEND starts.
    post_mux_byte_sel #(
        .N_BITS (N_BITS),
        .BYTE_W (BYTE_W),
        .BIDX_W (BIDX_W)
    ) u_byte_sel (
        .buf_bits (buf_s),
        .byte_idx (byte_idx_s),
        .byte_out (sel_byte_s)
    );

    // Next-state, capture and handshake logic.
    always_comb begin
        state_s    = state_r;
        buf_s      = buf_r;
        rx_cnt_s   = rx_cnt_r;
        byte_idx_s = byte_idx_r;
        err_s      = err_r;
        tx_valid_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // The buffer is cleared on start too, so a short sweep never leaks old bits.
                if (start) begin
                    state_s    = COLLECT;
                    buf_s      = {N_BITS{1'b0}};
                    rx_cnt_s   = {CNT_W{1'b0}};
                    byte_idx_s = {BIDX_W{1'b0}};
                    err_s      = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    buf_s[idx] = bit_in;
                    if (rx_cnt_r != CNT_MAX) begin
                        rx_cnt_s = rx_cnt_r + CNT_ONE;
                    end else begin
                        rx_cnt_s = rx_cnt_r;
                    end
                    if (last) begin
                        err_s      = (({1'b0, rx_cnt_r} + {{CNT_W{1'b0}}, 1'b1}) != CNT_FULL);
                        state_s    = SEND;
                        tx_valid_s = 1'b1;
                    end else begin
                        state_s = COLLECT;
                    end
                end else begin
                    state_s = COLLECT;
                end
            end
            SEND: begin
                if (tx_valid_r && tx_ready) begin
                    if (byte_idx_r == LAST_BYTE) begin
                        state_s    = IDLE;
                        byte_idx_s = {BIDX_W{1'b0}};
                        done_s     = 1'b1;
                    end else begin
                        byte_idx_s = byte_idx_r + BIDX_ONE;
                        tx_valid_s = 1'b1;
                    end
                end else begin
                    tx_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output byte is zero whenever no byte is offered.
    always_comb begin
        if (tx_valid_s) begin
            tx_data_s = sel_byte_s;
        end else begin
            tx_data_s = {BYTE_W{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Buffer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_r      <= {N_BITS{1'b0}};
            rx_cnt_r   <= {CNT_W{1'b0}};
            byte_idx_r <= {BIDX_W{1'b0}};
            tx_data_r  <= {BYTE_W{1'b0}};
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            buf_r      <= buf_s;
            rx_cnt_r   <= rx_cnt_s;
            byte_idx_r <= byte_idx_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= (state_s != IDLE);
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: doc/post_mux_collector.md
# post_mux_collector

Receiving end of the post-mux serial path. While `post_mux_counter` sweeps the 7-bit mux index and raises `finished` on the last position, this block samples each selected PUF response bit into a 128-bit buffer at that index. When the sweep ends, it streams the buffer out as bytes over a valid/ready handshake to the UART transmitter. It sits between the arbiter/mux output and the serial TX path.

## Interface
Parameters:
- `N_BITS`, 128: response bits per sweep; must equal 2^`IDX_W` and be a multiple of 8.
- `IDX_W`, 7: index width; matches the counter output.
- `BYTE_W`, 8: output byte width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms a new sweep.
- `bit_in`  in  1  PUF response bit at the current mux index.
- `bit_valid`  in  1  `bit_in`/`idx` valid this cycle; driven from the counter enable.
- `idx`  in  `IDX_W`  current mux index; driven from the counter output.
- `last`  in  1  final index of the sweep; driven from the counter `finished`.
- `tx_data`  out  `BYTE_W`  byte to transmit.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts `tx_data`.
- `busy`  out  1  high in COLLECT and SEND.
- `done`  out  1  one-cycle pulse after the final byte is accepted.
- `err`  out  1  sticky flag: bit count at `last` was not `N_BITS`.

## Operation
- FSM states:
  - IDLE: `start` → COLLECT; clear `rx_cnt`, `byte_idx`, `err`.
  - COLLECT: on `bit_valid`, `buf[idx] <= bit_in` and `rx_cnt++`. On `bit_valid && last`, write the bit, then evaluate `err <= (rx_cnt + 1 != N_BITS)` and go to SEND.
  - SEND: `tx_valid = 1`, `tx_data = buf[8k+7:8k]`, where k = `byte_idx`. LSB of each byte is the lowest index. On `tx_valid && tx_ready`, `byte_idx++`. When the last byte is accepted, pulse `done` and go to IDLE.
- Byte count per sweep: `N_BITS/8` = 16, plus 1 with the parity option.
- `rx_cnt` is `IDX_W+1` bits wide and saturates at `N_BITS`; it never wraps.
- Duplicate indices overwrite the buffer entry but still increment `rx_cnt`, so they set `err`.
- Boundary rules:
  - `start` during COLLECT or SEND: ignored.
  - `bit_valid` or `last` in IDLE or SEND: ignored.
  - `last` without `bit_valid`: ignored.
  - `err` does not abort the transfer; the stream is sent regardless. `err` holds until the next `start` or `reset`.
  - `reset` mid-operation, in any state: next cycle the FSM is in IDLE, buffer and counters are zero, and all outputs are at their reset values. A partially sent stream is abandoned.

## Timing
- Reset values: `tx_data` = 0, `tx_valid` = 0, `busy` = 0, `done` = 0, `err` = 0, buffer = 0.
- `busy` rises the cycle after `start`.
- Bit capture: the bit is in the buffer the cycle after `bit_valid`.
- `tx_valid` rises the cycle after the `bit_valid && last` cycle, with byte 0 on `tx_data`. `err` is valid in that same cycle.
- `tx_data` is registered and held stable while `tx_valid && !tx_ready`.
- Back-to-back throughput: with `tx_ready` held high, one byte per cycle.
- Valid never drops without a handshake.
- `done` pulses the cycle after the final handshake; in that cycle `busy` = 0 and `tx_valid` = 0.
- `start` coincident with `done`: accepted, since the FSM is already in IDLE.

## Configuration
- Macro: `POST_MUX_PARITY_EN`.
- Defined: after the 16 data bytes, SEND emits one extra byte equal to the XOR of all 16 data bytes (17 handshakes). `done` pulses after the parity byte is accepted.
- Undefined: 16 bytes only; no parity logic is synthesized.

## Structure
- Shared package `post_mux_pkg`:
  - state enum (IDLE, COLLECT, SEND);
  - `N_BITS`, `IDX_W`, `BYTE_W`;
  - `NUM_BYTES = N_BITS/BYTE_W`;
  - `TX_BYTES` (`NUM_BYTES`, or +1 when parity is enabled).
- Sub-module `post_mux_byte_sel`: combinational byte slice of the buffer by `byte_idx`, plus the running-parity XOR. Its output is registered in the parent.

## Test plan
- Full sweep:
  - Stimulus: `start`; bits `bit_in = idx[0]` for idx 0..127, `last` at 127; `tx_ready` = 1.
  - Response: 16 bytes of 0xAA on consecutive cycles, `err` = 0, `done` one cycle after byte 15.
- Backpressure:
  - Stimulus: same sweep, `tx_ready` toggling 1,0,0,1,...
  - Response: `tx_data` held stable while stalled, no byte lost or duplicated, exactly 16 handshakes.
- Short sweep:
  - Stimulus: `start`; only idx 0..63 valid, `last` at idx 63.
  - Response: `err` = 1; 16 bytes sent, bytes 8..15 = 0x00.
- Reset mid-SEND:
  - Stimulus: assert `reset` after byte 5 is accepted.
  - Response: next cycle `tx_valid` = 0, `busy` = 0, `done` never pulses. A following full sweep of all-ones returns 0xFF×16.
- Ignored inputs:
  - Stimulus: `start` during COLLECT; `bit_valid` with `bit_in` = 1 in IDLE before `start`.
  - Response: sweep unaffected; buffer bit not set by the IDLE write.
- With `POST_MUX_PARITY_EN`:
  - Stimulus: sweep giving bytes 0x01..0x10.
  - Response: 17th byte = 0x10 (XOR of 0x01..0x10); `done` after the 17th handshake.
